// File: rtl/prio_irq_ctrl.sv
// Multi-level interrupt controller: latched pending requests, a registered mask stage,
// and a level-then-channel arbiter that holds each grant until it is acknowledged.
//
// state   | meaning
// S_IDLE  | no grant outstanding; pick a winner from the registered masked vector
// S_GRANT | grant presented on irq_valid/irq_lvl/irq_idx, held until ack
module prio_irq_ctrl #(
   parameter int NUM_CH  = 9,
   parameter int NUM_LVL = 3,
   parameter int RR_MODE = 0,
   localparam int IDX_W  = $clog2(NUM_CH),
   localparam int LVL_W  = ($clog2(NUM_LVL) > 0) ? $clog2(NUM_LVL) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_LVL*NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0]         en,
   input  logic                      ack,
   output logic [NUM_LVL-1:0]        lvl_any,
   output logic                      irq_valid,
   output logic [LVL_W-1:0]          irq_lvl,
   output logic [IDX_W-1:0]          irq_idx
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                      state_q;
   logic [NUM_LVL*NUM_CH-1:0]   pend_q, pend_d;
   logic [NUM_LVL*NUM_CH-1:0]   masked_q, masked_d;
   logic [NUM_LVL*NUM_CH-1:0]   cand;
   logic [NUM_LVL-1:0]          lvl_any_q, lvl_any_d;
   logic                        irq_valid_q;
   logic [LVL_W-1:0]            irq_lvl_q;
   logic [IDX_W-1:0]            irq_idx_q;
   logic [IDX_W-1:0]            ptr_q [NUM_LVL];
   logic                        haz_q;
   logic                        acked;
   int                          gnt_bit;

   logic                        win_any;
   logic [LVL_W-1:0]            win_lvl;
   logic [IDX_W-1:0]            win_idx;
   int                          start, best, bidx, rank;

   assign lvl_any   = lvl_any_q;
   assign irq_valid = irq_valid_q;
   assign irq_lvl   = irq_lvl_q;
   assign irq_idx   = irq_idx_q;

   // haz_q hides the just-acked bit while masked_q still reflects it for one cycle
   always_comb begin
      acked     = irq_valid_q & ack;
      gnt_bit   = int'(irq_lvl_q) * NUM_CH + int'(irq_idx_q);
      pend_d    = '0;
      masked_d  = '0;
      cand      = '0;
      lvl_any_d = '0;
      for (int l = 0; l < NUM_LVL; l++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            masked_d[l*NUM_CH+c] = pend_q[l*NUM_CH+c] & en[c];
            pend_d[l*NUM_CH+c]   = (pend_q[l*NUM_CH+c] & ~(acked && (l*NUM_CH+c == gnt_bit)))
                                   | req[l*NUM_CH+c];
            cand[l*NUM_CH+c]     = masked_q[l*NUM_CH+c] & ~(haz_q && (l*NUM_CH+c == gnt_bit));
         end
         lvl_any_d[l] = |masked_d[l*NUM_CH +: NUM_CH];
      end
   end

   // rank = distance from the level's start channel, wrapping; smallest rank wins
   always_comb begin
      win_any = 1'b0;
      win_lvl = '0;
      win_idx = '0;
      start   = 0;
      best    = NUM_CH;
      bidx    = 0;
      rank    = 0;
      for (int l = 0; l < NUM_LVL; l++) begin
         start = (RR_MODE != 0) ? int'(ptr_q[l]) : 0;
         best  = NUM_CH;
         bidx  = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (cand[l*NUM_CH+c]) begin
               rank = (c >= start) ? (c - start) : (c + NUM_CH - start);
               if (rank < best) begin
                  best = rank;
                  bidx = c;
               end
            end
         end
         if (!win_any && (best < NUM_CH)) begin
            win_any = 1'b1;
            win_lvl = LVL_W'(l);
            win_idx = IDX_W'(bidx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pend_q      <= '0;
         masked_q    <= '0;
         lvl_any_q   <= '0;
         irq_valid_q <= 1'b0;
         irq_lvl_q   <= '0;
         irq_idx_q   <= '0;
         haz_q       <= 1'b0;
         for (int l = 0; l < NUM_LVL; l++) ptr_q[l] <= '0;
      end else begin
         pend_q    <= pend_d;
         masked_q  <= masked_d;
         lvl_any_q <= lvl_any_d;
         haz_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_any) begin
                  irq_valid_q <= 1'b1;
                  irq_lvl_q   <= win_lvl;
                  irq_idx_q   <= win_idx;
                  state_q     <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (ack) begin
                  irq_valid_q <= 1'b0;
                  haz_q       <= 1'b1;
                  state_q     <= S_IDLE;
                  for (int l = 0; l < NUM_LVL; l++) begin
                     if (LVL_W'(l) == irq_lvl_q)
                        ptr_q[l] <= (irq_idx_q == IDX_W'(NUM_CH-1)) ? '0 : irq_idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Bench for prio_irq_ctrl: fixed-priority and round-robin instances driven in parallel,
// checked every cycle against a cycle-level reference model plus directed expectations.
module tb_prio_irq_ctrl;
   localparam int NC = 9;
   localparam int NL = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [NL*NC-1:0] req;
   logic [NC-1:0]   en;
   logic            ack;

   logic [NL-1:0] fp_any, rr_any;
   logic          fp_val, rr_val;
   logic [1:0]    fp_lvl, rr_lvl;
   logic [3:0]    fp_idx, rr_idx;

   prio_irq_ctrl #(.NUM_CH(NC), .NUM_LVL(NL), .RR_MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req(req), .en(en), .ack(ack),
      .lvl_any(fp_any), .irq_valid(fp_val), .irq_lvl(fp_lvl), .irq_idx(fp_idx));

   prio_irq_ctrl #(.NUM_CH(NC), .NUM_LVL(NL), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .en(en), .ack(ack),
      .lvl_any(rr_any), .irq_valid(rr_val), .irq_lvl(rr_lvl), .irq_idx(rr_idx));

   int nvec = 0;
   int nerr = 0;

   // reference model, index 0 = fixed priority, 1 = round robin
   bit m_pend [2][NL][NC];
   bit m_mask [2][NL][NC];
   bit m_any  [2][NL];
   bit m_val  [2];
   int m_lvl  [2];
   int m_idx  [2];
   int m_ptr  [2][NL];
   bit m_haz  [2];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit acked, ohaz, found;
      int al, ai, c;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int l = 0; l < NL; l++) begin
               for (int j = 0; j < NC; j++) begin
                  m_pend[k][l][j] = 0;
                  m_mask[k][l][j] = 0;
               end
               m_any[k][l] = 0;
               m_ptr[k][l] = 0;
            end
            m_val[k] = 0; m_lvl[k] = 0; m_idx[k] = 0; m_haz[k] = 0;
         end else begin
            acked = m_val[k] && ack;
            al    = m_lvl[k];
            ai    = m_idx[k];
            ohaz  = m_haz[k];
            if (m_val[k]) begin
               if (ack) begin
                  m_val[k]     = 0;
                  m_ptr[k][al] = (ai + 1) % NC;
               end
            end else begin
               found = 0;
               for (int l = 0; l < NL && !found; l++) begin
                  for (int s = 0; s < NC && !found; s++) begin
                     c = ((k == 1 ? m_ptr[k][l] : 0) + s) % NC;
                     if (m_mask[k][l][c] && !(ohaz && l == al && c == ai)) begin
                        found = 1; m_val[k] = 1; m_lvl[k] = l; m_idx[k] = c;
                     end
                  end
               end
            end
            m_haz[k] = acked;
            for (int l = 0; l < NL; l++) begin
               m_any[k][l] = 0;
               for (int j = 0; j < NC; j++) begin
                  m_mask[k][l][j] = m_pend[k][l][j] && en[j];
                  if (m_mask[k][l][j]) m_any[k][l] = 1;
               end
            end
            for (int l = 0; l < NL; l++)
               for (int j = 0; j < NC; j++)
                  m_pend[k][l][j] = (m_pend[k][l][j] && !(acked && l == al && j == ai))
                                    || req[l*NC+j];
         end
      end
   endtask

   function automatic logic [NL-1:0] any_vec(int k);
      logic [NL-1:0] v;
      for (int l = 0; l < NL; l++) v[l] = m_any[k][l];
      return v;
   endfunction

   task automatic check_model();
      chk("fp_valid", fp_val, m_val[0]);
      chk("fp_any",   fp_any, any_vec(0));
      chk("fp_lvl",   fp_lvl, m_lvl[0]);
      chk("fp_idx",   fp_idx, m_idx[0]);
      chk("rr_valid", rr_val, m_val[1]);
      chk("rr_any",   rr_any, any_vec(1));
      chk("rr_lvl",   rr_lvl, m_lvl[1]);
      chk("rr_idx",   rr_idx, m_idx[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; ack = 1'b0; en = '1;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int g[$];
      int e3[3];
      int e4[5];
      e3 = '{2, 5, 8};
      e4 = '{0, 4, 8, 0, 4};

      // reset with every request asserted
      rst_n = 1'b0; req = '1; en = '1; ack = 1'b0;
      tick(); tick();
      chk("t1_rst_valid", fp_val, 0);
      chk("t1_rst_any",   fp_any, 0);
      rst_n = 1'b1;
      tick(); tick();
      chk("t1_early_valid", fp_val, 0);
      tick();
      chk("t1_valid", fp_val, 1);
      chk("t1_lvl",   fp_lvl, 0);
      chk("t1_idx",   fp_idx, 0);

      // level priority: (2,1) first, then (0,7) and (2,4) together
      do_reset();
      req[2*NC+1] = 1'b1;
      tick();
      req = '0; req[7] = 1'b1; req[2*NC+4] = 1'b1;
      tick();
      req = '0;
      tick();
      chk("t2_valid0", fp_val, 1);
      chk("t2_lvl0",   fp_lvl, 2);
      chk("t2_idx0",   fp_idx, 1);
      chk("t2_any0",   fp_any, 3'b101);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t2_gap", fp_val, 0);
      tick();
      chk("t2_valid1", fp_val, 1);
      chk("t2_lvl1",   fp_lvl, 0);
      chk("t2_idx1",   fp_idx, 7);
      chk("t2_any1",   fp_any, 3'b101);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      chk("t2_any2",   fp_any, 3'b100);
      chk("t2_lvl2",   fp_lvl, 2);
      chk("t2_idx2",   fp_idx, 4);

      // fixed priority within a level, ack held high
      do_reset();
      req[NC+2] = 1'b1; req[NC+5] = 1'b1; req[NC+8] = 1'b1;
      tick();
      req = '0; ack = 1'b1;
      g.delete();
      for (int i = 0; i < 10; i++) begin
         tick();
         if (fp_val) g.push_back(int'(fp_idx));
      end
      ack = 1'b0;
      chk("t3_cnt", g.size(), 3);
      for (int i = 0; i < 3; i++) chk("t3_idx", (i < g.size()) ? g[i] : 99, e3[i]);

      // round robin with requests held, wrap-around
      do_reset();
      req[NC+0] = 1'b1; req[NC+4] = 1'b1; req[NC+8] = 1'b1;
      ack = 1'b1;
      g.delete();
      for (int i = 0; i < 14; i++) begin
         tick();
         if (rr_val) g.push_back(int'(rr_idx));
      end
      req = '0; ack = 1'b0;
      chk("t4_cnt_ge5", (g.size() >= 5) ? 1 : 0, 1);
      for (int i = 0; i < 5; i++) chk("t4_idx", (i < g.size()) ? g[i] : 99, e4[i]);

      // enable mask
      do_reset();
      en[3] = 1'b0;
      req[3] = 1'b1;
      tick();
      req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_masked_valid", fp_val, 0);
         chk("t5_masked_any0",  fp_any[0], 0);
      end
      en[3] = 1'b1;
      tick(); tick();
      chk("t5_valid", fp_val, 1);
      chk("t5_lvl",   fp_lvl, 0);
      chk("t5_idx",   fp_idx, 3);

      // grant held through input churn, then reset mid-grant
      for (int i = 0; i < 10; i++) begin
         req = (NL*NC)'($urandom);
         en  = NC'($urandom);
         tick();
         chk("t6_hold_valid", fp_val, 1);
         chk("t6_hold_lvl",   fp_lvl, 0);
         chk("t6_hold_idx",   fp_idx, 3);
      end
      rst_n = 1'b0; req = '0; en = '1;
      tick();
      chk("t6_rst_valid", fp_val, 0);
      chk("t6_rst_any",   fp_any, 0);
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("t6_cleared_valid", fp_val, 0);
      chk("t6_cleared_any",   fp_any, 0);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         req   = (NL*NC)'($urandom & $urandom & $urandom);
         en    = NC'($urandom | $urandom);
         ack   = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 149) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
